// File: rtl/nou_fifo_arb_ctrl.sv
// Shares one FIFO RAM among NREQ round-robin write requesters and streams the
// read side out through a 2-entry skid buffer that hides the RAM read latency.
module nou_fifo_arb_ctrl #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 512,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NREQ-1:0]               req_valid_i,
    input  logic [NREQ*WIDTH-1:0]         req_data_i,
    output logic [NREQ-1:0]               req_ready_o,
    output logic                          fifo_wr_en_o,
    output logic [WIDTH-1:0]              fifo_wr_data_o,
    output logic                          fifo_rd_en_o,
    input  logic [WIDTH-1:0]              fifo_rd_data_i,
    input  logic                          fifo_full_i,
    input  logic                          fifo_empty_i,
    output logic                          out_valid_o,
    output logic [WIDTH-1:0]              out_data_o,
    input  logic                          out_ready_i,
    output logic [$clog2(DEPTH):0]        level_o,
    output logic                          error_o
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]    ptr_r;
    logic [LW-1:0]    count_r;
    logic             inflight_r;
    logic [1:0]       skid_cnt_r;
    logic [WIDTH-1:0] skid_q0_r;
    logic [WIDTH-1:0] skid_q1_r;
    logic             error_r;

    logic             grant_any_s;
    logic [PW-1:0]    grant_idx_s;
    logic             space_s;
    logic             wr_en_s;
    logic [WIDTH-1:0] wr_data_s;
    logic             rd_en_s;
    logic             pop_s;
    logic             out_valid_s;
    logic             check_bad_s;

    // Round-robin search starting one past the last granted requester.
    always_comb begin : rr_pick
        logic [PW-1:0] cand;
        cand        = '0;
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr_r) + k) % NREQ);
            if (!grant_any_s && req_valid_i[cand]) begin
                grant_any_s = 1'b1;
                grant_idx_s = cand;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Write-side handshake; outputs are forced low while rstn is asserted.
    always_comb begin
        space_s     = (count_r < LW'(DEPTH));
        req_ready_o = '0;
        wr_data_s   = req_data_i[0 +: WIDTH];
        if (rstn && grant_any_s && space_s) begin
            req_ready_o = NREQ'(1) << grant_idx_s;
        end else begin
            req_ready_o = '0;
        end
        wr_en_s = |(req_valid_i & req_ready_o);
        for (int i = 0; i < NREQ; i++) begin
            if (wr_en_s && (PW'(i) == grant_idx_s)) begin
                wr_data_s = req_data_i[i*WIDTH +: WIDTH];
            end else begin
                wr_data_s = wr_data_s;
            end
        end
        if (rstn) begin
            fifo_wr_data_o = wr_data_s;
        end else begin
            fifo_wr_data_o = '0;
        end
        fifo_wr_en_o = wr_en_s;
    end

    // Read issue: only when data is committed to RAM and the skid can take it.
    always_comb begin
        out_valid_s = (skid_cnt_r != 2'd0);
        pop_s       = out_valid_s & out_ready_i;
        if (count_r != '0) begin
            rd_en_s = ({1'b0, skid_cnt_r} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s});
        end else begin
            rd_en_s = 1'b0;
        end
        fifo_rd_en_o = rd_en_s;
        out_valid_o  = out_valid_s;
        out_data_o   = skid_q0_r;
        level_o      = count_r;
        error_o      = error_r;
        check_bad_s  = ((count_r == LW'(DEPTH)) != fifo_full_i) ||
                       ((count_r == '0) != fifo_empty_i);
    end

    // Arbitration pointer, RAM occupancy, read-in-flight flag and sticky error.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r      <= PW'(NREQ - 1);
            count_r    <= '0;
            inflight_r <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                ptr_r <= grant_idx_s;
            end else begin
                ptr_r <= ptr_r;
            end
            count_r    <= count_r + {{(LW-1){1'b0}}, wr_en_s} - {{(LW-1){1'b0}}, rd_en_s};
            inflight_r <= rd_en_s;
            error_r    <= error_r | check_bad_s;
        end
    end

    // Skid buffer: entry 0 is always the oldest; push lands in the next free slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skid_cnt_r <= 2'd0;
            skid_q0_r  <= '0;
            skid_q1_r  <= '0;
        end else begin
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (skid_cnt_r == 2'd0) begin
                        skid_q0_r <= fifo_rd_data_i;
                    end else begin
                        skid_q1_r <= fifo_rd_data_i;
                    end
                    skid_cnt_r <= skid_cnt_r + 2'd1;
                end
                2'b01: begin
                    skid_q0_r  <= skid_q1_r;
                    skid_cnt_r <= skid_cnt_r - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt_r == 2'd1) begin
                        skid_q0_r <= fifo_rd_data_i;
                    end else begin
                        skid_q0_r <= skid_q1_r;
                        skid_q1_r <= fifo_rd_data_i;
                    end
                end
                default: begin
                    skid_cnt_r <= skid_cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nou_fifo_arb_ctrl.sv
// Directed bench for nou_fifo_arb_ctrl with a behavioural 1-cycle-latency FIFO.
module tb_nou_fifo_arb_ctrl;

    localparam int NREQ  = 4;
    localparam int WIDTH = 512;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_wr_en;
    logic [WIDTH-1:0]      fifo_wr_data;
    logic                  fifo_rd_en;
    logic [WIDTH-1:0]      fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_ready;
    logic [LW-1:0]         level;
    logic                  error;
    logic                  force_ne;

    always #5 clk = ~clk;

    nou_fifo_arb_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
        .fifo_wr_en_o(fifo_wr_en), .fifo_wr_data_o(fifo_wr_data),
        .fifo_rd_en_o(fifo_rd_en), .fifo_rd_data_i(fifo_rd_data),
        .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
        .level_o(level), .error_o(error)
    );

    // Behavioural shared FIFO: registered read data, same rstn.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [3:0]       wp, rp;
    int               fcnt;

    always_ff @(posedge clk) begin
        if (fifo_wr_en) mem[wp] <= fifo_wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= '0; rp <= '0; fcnt <= 0; fifo_rd_data <= '0;
        end else begin
            if (fifo_wr_en) wp <= wp + 4'd1;
            if (fifo_rd_en) begin
                fifo_rd_data <= mem[rp];
                rp <= rp + 4'd1;
            end
            fcnt <= fcnt + int'(fifo_wr_en) - int'(fifo_rd_en);
        end
    end

    assign fifo_full  = (fcnt == DEPTH);
    assign fifo_empty = (fcnt == 0) && !force_ne;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; req_valid = '0; out_ready = 1'b0; force_ne = 1'b0;
        tick(); tick();
        rstn = 1'b1;
    endtask

    task automatic set_data(input int r, input logic [WIDTH-1:0] d);
        req_data[r*WIDTH +: WIDTH] = d;
    endtask

    typedef struct packed {
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] e_ready;
        logic       e_wr;
        logic       e_rd;
        logic [4:0] e_lvl;
        logic       e_ov;
        logic [7:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, input logic o, input logic [3:0] r,
                                input logic w, input logic rd, input logic [4:0] l,
                                input logic ov, input logic [7:0] d);
        vec_t t;
        t.valid = v; t.ordy = o; t.e_ready = r; t.e_wr = w; t.e_rd = rd;
        t.e_lvl = l; t.e_ov = ov; t.e_data = d;
        return t;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [14];
        int   nxt, got, full_wr_seen;
        logic [WIDTH-1:0] exp_d;

        tbl[0]  = mk(4'hF, 1'b1, 4'b0001, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00);
        tbl[1]  = mk(4'hF, 1'b1, 4'b0010, 1'b1, 1'b1, 5'd1, 1'b0, 8'h00);
        tbl[2]  = mk(4'hF, 1'b1, 4'b0100, 1'b1, 1'b1, 5'd1, 1'b0, 8'h00);
        tbl[3]  = mk(4'hF, 1'b1, 4'b1000, 1'b1, 1'b1, 5'd1, 1'b1, 8'h10);
        tbl[4]  = mk(4'hF, 1'b1, 4'b0001, 1'b1, 1'b1, 5'd1, 1'b1, 8'h11);
        tbl[5]  = mk(4'hF, 1'b1, 4'b0010, 1'b1, 1'b1, 5'd1, 1'b1, 8'h12);
        tbl[6]  = mk(4'hF, 1'b1, 4'b0100, 1'b1, 1'b1, 5'd1, 1'b1, 8'h13);
        tbl[7]  = mk(4'hF, 1'b1, 4'b1000, 1'b1, 1'b1, 5'd1, 1'b1, 8'h10);
        tbl[8]  = mk(4'h5, 1'b1, 4'b0001, 1'b1, 1'b1, 5'd1, 1'b1, 8'h11);
        tbl[9]  = mk(4'h5, 1'b1, 4'b0100, 1'b1, 1'b1, 5'd1, 1'b1, 8'h12);
        tbl[10] = mk(4'h0, 1'b1, 4'b0000, 1'b0, 1'b1, 5'd1, 1'b1, 8'h13);
        tbl[11] = mk(4'h0, 1'b1, 4'b0000, 1'b0, 1'b0, 5'd0, 1'b1, 8'h10);
        tbl[12] = mk(4'h0, 1'b1, 4'b0000, 1'b0, 1'b0, 5'd0, 1'b1, 8'h12);
        tbl[13] = mk(4'h0, 1'b1, 4'b0000, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00);

        req_data = '0;
        do_reset();

        // Reset state
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_level", level, 0);
        chk("rst_error", error, 0);
        tick();

        // Single write from requester 2
        set_data(2, 512'hA5);
        req_valid = 4'b0100; out_ready = 1'b1;
        #1;
        chk("single_ready", req_ready, 4'b0100);
        chk("single_wr_en", fifo_wr_en, 1);
        chk("single_wr_data", fifo_wr_data, 512'hA5);
        tick();
        req_valid = '0;
        #1;
        chk("single_rd_en_t1", fifo_rd_en, 1);
        chk("single_level_t1", level, 1);
        tick();
        chk("single_ov_t2", out_valid, 0);
        tick();
        chk("single_ov_t3", out_valid, 1);
        chk("single_data_t3", out_data, 512'hA5);
        chk("single_level_t3", level, 0);
        tick();
        chk("single_ov_t4", out_valid, 0);

        // Round-robin table
        do_reset();
        for (int r = 0; r < NREQ; r++) set_data(r, WIDTH'(8'h10 + r));
        for (int i = 0; i < 14; i++) begin
            req_valid = tbl[i].valid;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].e_ready);
            chk($sformatf("vec%0d_wr_en", i), fifo_wr_en, tbl[i].e_wr);
            chk($sformatf("vec%0d_rd_en", i), fifo_rd_en, tbl[i].e_rd);
            chk($sformatf("vec%0d_level", i), level, tbl[i].e_lvl);
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_data);
            tick();
        end
        req_valid = '0;

        // Fill with consumer stalled: requester 0 offers 0..19
        out_ready = 1'b0; nxt = 0; full_wr_seen = 0;
        for (int c = 0; c < 40; c++) begin
            set_data(0, WIDTH'(nxt));
            req_valid = (nxt < 20) ? 4'b0001 : 4'b0000;
            #1;
            if (level == LW'(DEPTH) && fifo_wr_en) full_wr_seen++;
            if (req_ready[0] && req_valid[0]) nxt++;
            tick();
        end
        chk("fill_accepted", nxt, 18);
        chk("fill_wr_at_full", full_wr_seen, 0);
        #1;
        chk("fill_level", level, 16);
        chk("fill_ready", req_ready, 0);
        chk("fill_wr_en", fifo_wr_en, 0);
        chk("fill_out_valid", out_valid, 1);
        tick();

        // Free one skid slot, then the held write lands as the RAM read drains
        got = 0;
        set_data(0, WIDTH'(18));
        req_valid = 4'b0001; out_ready = 1'b1;
        #1;
        chk("free_rd_en", fifo_rd_en, 1);
        chk("free_ready", req_ready, 0);
        chk("free_out_data", out_data, 0);
        if (out_valid) got++;
        tick();
        out_ready = 1'b0;
        #1;
        chk("refill_ready", req_ready, 4'b0001);
        chk("refill_wr_en", fifo_wr_en, 1);
        chk("refill_rd_en", fifo_rd_en, 0);
        chk("refill_level_before", level, 15);
        tick();
        req_valid = '0;
        #1;
        chk("refill_level_after", level, 16);

        // Drain under random backpressure: 0..18 in order
        for (int c = 0; c < 600 && got < 19; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                exp_d = WIDTH'(got);
                chk($sformatf("drain_data%0d", got), out_data, exp_d);
                got++;
            end
            tick();
        end
        chk("drain_count", got, 19);
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("drain_level", level, 0);
        chk("drain_out_valid", out_valid, 0);
        chk("drain_error", error, 0);

        // Reset while a read is in flight
        set_data(1, 512'h77);
        req_valid = 4'b0010;
        #1;
        chk("mid_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        #1;
        chk("mid_rd_en", fifo_rd_en, 1);
        tick();
        set_data(1, 512'h55);
        req_valid = 4'b0010;
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_wr_en", fifo_wr_en, 0);
        chk("mid_rst_wr_data", fifo_wr_data, 0);
        chk("mid_rst_rd_en", fifo_rd_en, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_level", level, 0);
        tick();
        req_valid = '0;
        tick();
        rstn = 1'b1;
        set_data(1, 512'h3C);
        req_valid = 4'b0010;
        #1;
        chk("post_rst_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        tick(); tick();
        chk("post_rst_out_valid", out_valid, 1);
        chk("post_rst_out_data", out_data, 512'h3C);
        chk("post_rst_error", error, 0);
        tick(); tick();

        // Empty flag disagrees with level 0
        chk("err_level0", level, 0);
        force_ne = 1'b1;
        #1;
        chk("err_same_cycle", error, 0);
        tick();
        chk("err_rise", error, 1);
        force_ne = 1'b0;
        tick(); tick();
        chk("err_sticky", error, 1);
        do_reset();
        #1;
        chk("err_cleared", error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
